// File: rtl/median_window_gen.sv
// 3x3 neighbourhood builder for the median sort network: two line buffers plus a shifting window.
// Define MEDWIN_EOF_EN to add an eof pulse alongside the last window of each frame.
module median_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        sof,
  output logic [71:0] win,
  output logic        win_valid
`ifdef MEDWIN_EOF_EN
  ,
  output logic        eof
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, c;
  logic [RW-1:0] row_q, row_d, r;

  logic [7:0] lb0_q [IMG_W];
  logic [7:0] lb1_q [IMG_W];

  // Window cells indexed [column][row]; column 2 is the newest.
  logic [7:0] wc_q [3][3];
  logic [7:0] wc_d [3][3];

  logic [71:0] win_q, win_d;
  logic        win_valid_q, win_valid_d;

  always_comb begin
    c = sof ? '0 : col_q;
    r = sof ? '0 : row_q;

    if (c == COL_LAST) begin
      col_d = '0;
      row_d = (r == ROW_LAST) ? '0 : r + RW'(1);
    end else begin
      col_d = c + CW'(1);
      row_d = r;
    end

    for (int i = 0; i < 3; i++) begin
      wc_d[0][i] = wc_q[1][i];
      wc_d[1][i] = wc_q[2][i];
    end
    wc_d[2][0] = lb1_q[c];
    wc_d[2][1] = lb0_q[c];
    wc_d[2][2] = pix_in;

    win_d = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        win_d[8*(3*rr+cc) +: 8] = wc_d[cc][rr];
      end
    end

    win_valid_d = pix_valid && (r >= RW'(2)) && (c >= CW'(2));
  end

  // Line buffers are never cleared: rows 0 and 1 of a frame never emit a window.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_q[c] <= lb0_q[c];
      lb0_q[c] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          wc_q[i][j] <= '0;
        end
      end
    end else begin
      win_valid_q <= win_valid_d;
      if (pix_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            wc_q[i][j] <= wc_d[i][j];
          end
        end
      end
      // win only moves on a qualifying pixel so it stays stable between pulses.
      if (win_valid_d) begin
        win_q <= win_d;
      end
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;

`ifdef MEDWIN_EOF_EN
  logic eof_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      eof_q <= 1'b0;
    end else begin
      eof_q <= win_valid_d && (r == ROW_LAST) && (c == COL_LAST);
    end
  end

  assign eof = eof_q;
`endif

endmodule

// File: doc/median_window_gen.md
# median_window_gen

- Builds the 3x3 pixel neighbourhood consumed by the median filter's compare/sort network, from a raster-order 8-bit pixel stream.
- Holds two line buffers and a 3x3 register window.
- Emits one registered 72-bit window, with a valid pulse, for every input pixel whose full 3x3 neighbourhood lies inside the image.
- Sits between the pixel source and the median sorting stage.

## Interface
Parameters:
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- pix_in  input  8  unsigned pixel, raster order
- pix_valid  input  1  pix_in accepted on this edge when high
- sof  input  1  start of frame; qualified by pix_valid
- win  output  72  window; byte k = w_k, k = 3*r + c, r/c in 0..2
- win_valid  output  1  one-cycle pulse, win is new
- eof  output  1  only with MEDWIN_EOF_EN; see Configuration

Window layout:
- w0 is top-left.
- w8 is bottom-right and equals the accepted pixel.

## Operation
Storage:
- Line buffers lb0 (previous line) and lb1 (line before that), IMG_W x 8 bits each, indexed by col.

Counters:
- col: 0..IMG_W-1.
- row: 0..IMG_H-1.

On each edge with pix_valid=1, let (r, c) be the pixel position:
- If sof=1, position is (0, 0) regardless of counters.
- Otherwise position is (row, col).
- New column = {top: lb1[c], mid: lb0[c], bottom: pix_in}.
- Window columns shift left: col0 <- col1, col1 <- col2, col2 <- new column.
- lb1[c] <- lb0[c]; lb0[c] <- pix_in. Reads use pre-write contents.
- Counters advance from (r, c):
  - c < IMG_W-1: col = c+1.
  - Otherwise col = 0 and row = r+1, wrapping to 0 after IMG_H-1.
- win_valid next cycle = (r >= 2) && (c >= 2).

Other rules:
- pix_valid=0: nothing changes, win_valid=0, win holds.
- sof with pix_valid=0 is ignored.
- No backpressure; consumer must accept every pulse.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Border pixels produce no window.

Reset:
- col=0, row=0, all window registers 0, win=0, win_valid=0, eof=0.
- Line buffer contents are not cleared. Stale data is never emitted because rows 0-1 produce no window.
- Reset mid-frame: the next accepted pixel is treated as (0, 0) whether or not sof is asserted.

## Timing
- Latency: win/win_valid are registered, valid in the cycle after the edge that accepted the qualifying pixel.
- Throughput: one pixel per clock; arbitrary gaps allowed.
- win is stable between pulses.
- win_valid is never high two cycles without two consecutive accepted qualifying pixels.
- The line buffer read-before-write for the same index happens in one edge. No read-after-write hazard: an index is rewritten only once per line.

## Configuration
MEDWIN_EOF_EN:
- Defined: port eof exists. eof pulses high in the same cycle as the win_valid for pixel (IMG_H-1, IMG_W-1); otherwise 0; reset 0.
- Undefined: no eof port, no logic. All other behaviour identical.

## Test plan
Bench uses IMG_W=4, IMG_H=4, pixel value = 16*row + col.
- Reset, then a full frame of 16 pixels with sof on the first, pix_valid continuous.
  - Exactly 4 pulses, one cycle after pixels (2,2), (2,3), (3,2), (3,3).
  - First win bytes w0..w8 = 00,01,02,10,11,12,20,21,22.
- Same frame with pix_valid low for 3 cycles after every pixel.
  - Identical window sequence.
  - win holds between pulses.
- Two back-to-back frames, sof on each first pixel.
  - 8 pulses.
  - First window of frame 2 equals frame 1's (00..22), with no stale mixing.
- sof asserted at pixel 6 of frame 1, then a full 16-pixel frame.
  - No pulses before frame 2's (2,2).
  - Then 4 correct windows.
- rst pulsed after 10 pixels, then 16 pixels without sof.
  - All outputs 0 the cycle after reset.
  - 4 correct windows, first at 00..22.
- MEDWIN_EOF_EN defined, full frame.
  - eof high exactly once, coincident with the pulse carrying w8 = 0x33.
